// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round controllers.
package aes_pkg;
  localparam int NR          = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_KEYINIT = 5'd1,
    ST_ISHIFT  = 5'd2,
    ST_ISUB    = 5'd3,
    ST_IADD    = 5'd4,
    ST_IMIX    = 5'd5,
    ST_DONE    = 5'd6
  } aes_inv_state_t;
endpackage

// File: rtl/aes_inv_rounds_if.sv
// Controller-side bundle: start/block, round-key handshake, datapath unit handshakes, status.
interface aes_inv_rounds_if;
  import aes_pkg::*;

  logic                   start;
  logic [AES_BLOCK_W-1:0] cyphertext;
  logic                   key_req;
  logic [3:0]             key_idx;
  logic [AES_BLOCK_W-1:0] roundkey;
  logic                   key_valid;
  logic [AES_BLOCK_W-1:0] sreg;
  logic [AES_BLOCK_W-1:0] invshifted;
  logic                   subenable;
  logic                   subdone;
  logic [AES_BLOCK_W-1:0] invsubbed;
  logic                   mixenable;
  logic                   mixdone;
  logic [AES_BLOCK_W-1:0] invmixed;
  logic [3:0]             round;
  logic                   busy;
  logic                   done;
  logic [AES_BLOCK_W-1:0] plaintext;

  modport master (
    input  start, cyphertext, roundkey, key_valid, invshifted,
           subdone, invsubbed, mixdone, invmixed,
    output key_req, key_idx, sreg, subenable, mixenable,
           round, busy, done, plaintext
  );

  modport slave (
    output start, cyphertext, roundkey, key_valid, invshifted,
           subdone, invsubbed, mixdone, invmixed,
    input  key_req, key_idx, sreg, subenable, mixenable,
           round, busy, done, plaintext
  );
endinterface

// File: rtl/aes_round_ctr.sv
// Loadable 4-bit AES round down-counter (load NR, decrement, zero flag).
// Latency: count updates on the edge after load/dec; is_zero is combinational.
// Backpressure: none; decrement saturates at zero.
module aes_round_ctr
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       is_zero
);

  assign is_zero = (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(NR);
    end else if (dec && !is_zero) begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/aes_inv_rounds.sv
// AES-128 inverse-cipher round controller; optional AES_INV_ALARM_EN adds a final-round alarm port.
// Latency: 41 cycles start-to-done with zero-wait key/sub/mix responders.
// Backpressure: every request is held with stable index until its done/valid; start ignored while busy.
module aes_inv_rounds
  import aes_pkg::*;
(
  input  logic             int_osc,
  input  logic             reset,
  aes_inv_rounds_if.master bus
`ifdef AES_INV_ALARM_EN
  ,
  output logic             alarm
`endif
);

  aes_inv_state_t         state, nstate;
  logic [AES_BLOCK_W-1:0] sreg_q;
  logic [AES_BLOCK_W-1:0] ct_q;
  logic [3:0]             round_q;
  logic                   round_zero;
  logic                   accept_start;
  logic                   round_dec;

  assign accept_start = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign round_dec    = (state == ST_KEYINIT && bus.key_valid) ||
                        (state == ST_IMIX    && bus.mixdone);

  aes_round_ctr u_round_ctr (
    .clk     (int_osc),
    .rst_n   (reset),
    .load    (accept_start),
    .dec     (round_dec),
    .cnt     (round_q),
    .is_zero (round_zero)
  );

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:    if (bus.start)     nstate = ST_KEYINIT;
      ST_KEYINIT: if (bus.key_valid) nstate = ST_ISHIFT;
      ST_ISHIFT:                     nstate = ST_ISUB;
      ST_ISUB:    if (bus.subdone)   nstate = ST_IADD;
      ST_IADD:    if (bus.key_valid) nstate = round_zero ? ST_DONE : ST_IMIX;
      ST_IMIX:    if (bus.mixdone)   nstate = ST_ISHIFT;
      ST_DONE:    if (bus.start)     nstate = ST_KEYINIT;
      default:                       nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.key_req   = 1'b0;
    bus.key_idx   = 4'd0;
    bus.subenable = 1'b0;
    bus.mixenable = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.plaintext = '0;
    case (state)
      ST_KEYINIT: begin
        bus.key_req = 1'b1;
        bus.key_idx = 4'(NR);
        bus.busy    = 1'b1;
      end
      ST_ISHIFT: bus.busy = 1'b1;
      ST_ISUB: begin
        bus.subenable = 1'b1;
        bus.busy      = 1'b1;
      end
      ST_IADD: begin
        bus.key_req = 1'b1;
        bus.key_idx = round_q;
        bus.busy    = 1'b1;
      end
      ST_IMIX: begin
        bus.mixenable = 1'b1;
        bus.busy      = 1'b1;
      end
      ST_DONE: begin
        bus.done      = 1'b1;
        bus.plaintext = sreg_q;
      end
      default: ;
    endcase
  end

`ifdef AES_INV_ALARM_EN
  assign alarm = round_zero &&
                 (state == ST_ISHIFT || state == ST_ISUB || state == ST_IADD);
`endif

  assign bus.sreg  = sreg_q;
  assign bus.round = round_q;

  // The block is held locally so the source may change cyphertext once start is accepted.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      ct_q   <= '0;
    end else begin
      if (accept_start) ct_q <= bus.cyphertext;
      case (state)
        ST_KEYINIT: if (bus.key_valid) sreg_q <= ct_q ^ bus.roundkey;
        ST_ISHIFT:                     sreg_q <= bus.invshifted;
        ST_ISUB:    if (bus.subdone)   sreg_q <= bus.invsubbed;
        ST_IADD:    if (bus.key_valid) sreg_q <= sreg_q ^ bus.roundkey;
        ST_IMIX:    if (bus.mixdone)   sreg_q <= bus.invmixed;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_rounds.sv
// Bench for aes_inv_rounds: behavioural AES datapath/key responders with random stalls and a reference decrypt.
module tb_aes_inv_rounds;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic int_osc = 1'b0;
  logic reset   = 1'b0;
  always #5 int_osc = ~int_osc;

  aes_inv_rounds_if bus();
`ifdef AES_INV_ALARM_EN
  logic alarm;
`endif

  aes_inv_rounds dut (
    .int_osc (int_osc),
    .reset   (reset),
    .bus     (bus)
`ifdef AES_INV_ALARM_EN
    ,
    .alarm   (alarm)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_tab [11];
  logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // State byte (row r, column c) lives at byte index r + 4c, byte 0 in the MSBs.
  function automatic logic [127:0] inv_shift(input logic [127:0] v);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isb[v[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j-r+4)%4], v[127-8*(j+4*c) -: 8]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] ct);
    logic [127:0] s = ct ^ rk_tab[10];
    for (int r = 9; r >= 0; r--) begin
      s = inv_sub(inv_shift(s)) ^ rk_tab[r];
      if (r != 0) s = inv_mix(s);
    end
    return s;
  endfunction

  task automatic build_sbox();
    logic [7:0] x, y, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      y = 8'h01;
      if (x == 8'h00) y = 8'h00;
      else for (int k = 0; k < 254; k++) y = gmul(y, x);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      sb[i]  = s;
      isb[s] = x;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Datapath units and round-key source with programmable stalls and spurious strobes.
  int   sub_cnt = 0, mix_cnt = 0, key_cnt = 0, max_stall = 0;
  logic spur_sub = 1'b0, spur_mix = 1'b0, spur_key = 1'b0;
  bit   spur_en = 1'b0;

  assign bus.invshifted = inv_shift(bus.sreg);
  assign bus.invsubbed  = inv_sub(bus.sreg);
  assign bus.invmixed   = inv_mix(bus.sreg);
  assign bus.subdone    = (bus.subenable && sub_cnt == 0) || spur_sub;
  assign bus.mixdone    = (bus.mixenable && mix_cnt == 0) || spur_mix;
  assign bus.key_valid  = (bus.key_req && key_cnt == 0) || spur_key;
  assign bus.roundkey   = (bus.key_req && bus.key_idx <= 4'd10) ? rk_tab[bus.key_idx]
                                                                 : 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;

  always @(negedge int_osc) begin
    if (bus.subenable) begin if (sub_cnt > 0) sub_cnt--; end
    else sub_cnt = $urandom_range(0, max_stall);
    if (bus.mixenable) begin if (mix_cnt > 0) mix_cnt--; end
    else mix_cnt = $urandom_range(0, max_stall);
    if (bus.key_req) begin if (key_cnt > 0) key_cnt--; end
    else key_cnt = $urandom_range(0, max_stall);
    spur_sub = spur_en && ($urandom_range(0, 3) == 0);
    spur_mix = spur_en && ($urandom_range(0, 3) == 0);
    spur_key = spur_en && ($urandom_range(0, 3) == 0);
  end

  logic [3:0] idx_q [$];
  logic [3:0] held_idx = 4'd0;
  logic       prev_req = 1'b0;
  int         unstable = 0;

  always @(negedge int_osc) begin
    if (bus.key_req && !prev_req) begin
      idx_q.push_back(bus.key_idx);
      held_idx = bus.key_idx;
    end else if (bus.key_req && bus.key_idx !== held_idx) begin
      unstable++;
    end
    prev_req = bus.key_req;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int cyc = 0, alarm_n = 0, alarm_first = 0;

  task automatic count_alarm();
`ifdef AES_INV_ALARM_EN
    if (alarm === 1'b1) begin
      alarm_n++;
      if (alarm_first == 0) alarm_first = cyc;
    end
`endif
  endtask

  // Cycle 0 is the one in which start is sampled; returns in cycle 1.
  task automatic start_blk(input logic [127:0] ct);
    @(negedge int_osc);
    bus.cyphertext = ct;
    bus.start      = 1'b1;
    @(negedge int_osc);
    bus.start      = 1'b0;
    bus.cyphertext = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
  endtask

  task automatic wait_done(input int limit);
    alarm_n = 0;
    alarm_first = 0;
    count_alarm();
    while (bus.done !== 1'b1 && cyc < limit) begin
      @(negedge int_osc);
      cyc++;
      count_alarm();
    end
  endtask

  function automatic logic [127:0] ctl_vec();
    return 128'({bus.key_req, bus.key_idx, bus.subenable, bus.mixenable,
                 bus.round, bus.busy, bus.done});
  endfunction

  initial begin
    logic [127:0] key, ct, exp;
    logic [43:0]  got_seq, want_seq;

    build_sbox();
    bus.start      = 1'b0;
    bus.cyphertext = '0;
    repeat (3) @(negedge int_osc);
    chk("rst_sreg", bus.sreg, 128'd0);
    chk("rst_plaintext", bus.plaintext, 128'd0);
    chk("rst_ctl", ctl_vec(), 128'd0);
`ifdef AES_INV_ALARM_EN
    chk("rst_alarm", 128'(alarm), 128'd0);
`endif
    reset = 1'b1;

    // FIPS-197 C.1, zero-wait.
    expand(C1_KEY);
    start_blk(C1_CT);
    chk("c1_busy_cycle1", 128'({bus.busy, bus.done, bus.key_req, bus.key_idx}), 128'({2'b10, 1'b1, 4'd10}));
    wait_done(200);
    chk("c1_done_cycle", 128'(cyc), 128'd41);
    chk("c1_plaintext", bus.plaintext, C1_PT);
    chk("c1_done_idle", 128'({bus.busy, bus.key_req, bus.subenable, bus.mixenable}), 128'd0);
`ifdef AES_INV_ALARM_EN
    chk("c1_alarm_cycles", 128'(alarm_n), 128'd3);
    chk("c1_alarm_first", 128'(alarm_first), 128'd38);
`endif

    // Back-to-back start from DONE with a random block and key.
    key = {$urandom, $urandom, $urandom, $urandom};
    ct  = {$urandom, $urandom, $urandom, $urandom};
    expand(key);
    exp = dec_model(ct);
    start_blk(ct);
    chk("b2b_done_drop", 128'({bus.busy, bus.done, bus.plaintext == 128'd0}), 128'({2'b10, 1'b1}));
    wait_done(200);
    chk("b2b_done_cycle", 128'(cyc), 128'd41);
    chk("b2b_plaintext", bus.plaintext, exp);

    // Random 0-3 cycle stalls with spurious strobes; first pass uses C.1.
    max_stall = 3;
    spur_en   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      key = (k == 0) ? C1_KEY : {$urandom, $urandom, $urandom, $urandom};
      ct  = (k == 0) ? C1_CT  : {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      exp = dec_model(ct);
      idx_q.delete();
      unstable = 0;
      start_blk(ct);
      wait_done(2000);
      chk("stall_done_seen", 128'(bus.done), 128'd1);
      chk("stall_plaintext", bus.plaintext, (k == 0) ? C1_PT : exp);
      for (int i = 0; i < 11; i++) begin
        got_seq[43-4*i -: 4]  = (i < idx_q.size()) ? idx_q[i] : 4'hf;
        want_seq[43-4*i -: 4] = 4'(10 - i);
      end
      chk("stall_key_count", 128'(idx_q.size()), 128'd11);
      chk("stall_key_seq", 128'(got_seq), 128'(want_seq));
      chk("stall_key_stable", 128'(unstable), 128'd0);
    end
    spur_en   = 1'b0;
    max_stall = 0;

    // start pulsed mid-operation must be ignored.
    expand(C1_KEY);
    start_blk(C1_CT);
    while (cyc < 20) begin
      @(negedge int_osc);
      cyc++;
    end
    bus.start      = 1'b1;
    bus.cyphertext = {$urandom, $urandom, $urandom, $urandom};
    @(negedge int_osc);
    cyc++;
    bus.start = 1'b0;
    wait_done(200);
    chk("busy_start_cycle", 128'(cyc), 128'd41);
    chk("busy_start_plaintext", bus.plaintext, C1_PT);

    // Asynchronous reset in round 5 IMIX, then a clean C.1 run.
    max_stall = 3;
    start_blk(C1_CT);
    while (!(bus.round == 4'd5 && bus.mixenable) && cyc < 1000) begin
      @(negedge int_osc);
      cyc++;
    end
    chk("imix5_reached", 128'({bus.round, bus.mixenable}), 128'({4'd5, 1'b1}));
    #1 reset = 1'b0;
    #1;
    chk("abort_sreg", bus.sreg, 128'd0);
    chk("abort_plaintext", bus.plaintext, 128'd0);
    chk("abort_ctl", ctl_vec(), 128'd0);
`ifdef AES_INV_ALARM_EN
    chk("abort_alarm", 128'(alarm), 128'd0);
`endif
    max_stall = 0;
    repeat (2) @(negedge int_osc);
    chk("abort_hold_ctl", ctl_vec(), 128'd0);
    reset = 1'b1;
    start_blk(C1_CT);
    wait_done(200);
    chk("post_rst_cycle", 128'(cyc), 128'd41);
    chk("post_rst_plaintext", bus.plaintext, C1_PT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
